// File: rtl/aurora_rx_frame_parser_if.sv
// aurora_rx_frame_parser_if: payload stream leaving the RX frame parser.
// The master drives the word and its SOF/EOF marks; the slave drives out_ready.

interface aurora_rx_frame_parser_if;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof;
  logic        out_eof;

  modport master (
    output out_data,
    output out_valid,
    output out_sof,
    output out_eof,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_sof,
    input  out_eof,
    output out_ready
  );
endinterface

// File: rtl/aurora_rx_frame_parser.sv
// aurora_rx_frame_parser: delineates frames (sync header, payload, check trailer) in the
// 32-bit word stream read from the Aurora RX FIFO. It forwards the payload on a valid/ready
// stream with SOF/EOF marks, pulses frame_ok/frame_err and keeps saturating statistics.
// Define AURORA_FRAME_CHK_EN to build the XOR trailer check; without it every trailer is
// accepted and frame_err only flags an illegal length.

module aurora_rx_frame_parser #(
  parameter logic [15:0] SYNC_WORD = 16'hA5C3,
  parameter int unsigned MAX_LEN   = 1024,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                            user_clk,
  input  logic                            rst_in,
  input  logic [31:0]                     fifo_dat_i,
  input  logic                            fifo_empty_i,
  output logic                            fifo_rd_o,
  aurora_rx_frame_parser_if.master        out_if,
  output logic                            frame_ok,
  output logic                            frame_err,
  output logic [CNT_W-1:0]                frame_cnt,
  output logic [CNT_W-1:0]                err_cnt,
  output logic [CNT_W-1:0]                drop_cnt
);

  typedef enum logic [1:0] {StHunt, StCheckLen, StPayload, StTrailer} state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e      state_q;
  logic [1:0]  occ_q;
  logic        rd_q;
  logic [31:0] skid0_q;
  logic [31:0] skid1_q;
  logic [15:0] rem_q;
  logic        first_q;
`ifdef AURORA_FRAME_CHK_EN
  logic [31:0] chk_q;
`endif

  logic        head_vld;
  logic        hs;
  logic        pop;
  logic        pay_vld;
  logic [2:0]  level;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CntOne;
  endfunction

  // Head availability, word consumption and FIFO read credit.
  // The credit counts this cycle's pop so a full-rate stream never starves.
  always_comb begin
    head_vld  = (occ_q != 2'd0);
    hs        = (state_q == StPayload) && head_vld && out_if.out_ready;
    pop       = head_vld && ((state_q == StHunt) || (state_q == StTrailer) || hs);
    level     = {1'b0, occ_q} + {2'b00, rd_q} - {2'b00, pop};
    fifo_rd_o = ~rst_in & ~fifo_empty_i & (level < 3'd2);
  end

  // Payload stream is a direct view of the skid head; it holds until popped.
  always_comb begin
    pay_vld          = (state_q == StPayload) && head_vld;
    out_if.out_valid = pay_vld;
    out_if.out_data  = pay_vld ? skid0_q : '0;
    out_if.out_sof   = pay_vld & first_q;
    out_if.out_eof   = pay_vld & (rem_q == 16'd1);
  end

  // Remember a read issued last cycle; its data lands this cycle.
  always_ff @(posedge user_clk or posedge rst_in) begin
    if (rst_in) begin
      rd_q <= 1'b0;
    end else begin
      rd_q <= fifo_rd_o;
    end
  end

  // Two-entry skid buffer: skid0_q is the head, skid1_q the second entry.
  always_ff @(posedge user_clk or posedge rst_in) begin
    if (rst_in) begin
      occ_q   <= 2'd0;
      skid0_q <= '0;
      skid1_q <= '0;
    end else begin
      case ({rd_q, pop})
        2'b10: begin
          if (occ_q == 2'd0) begin
            skid0_q <= fifo_dat_i;
          end else begin
            skid1_q <= fifo_dat_i;
          end
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          skid0_q <= skid1_q;
          occ_q   <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            skid0_q <= fifo_dat_i;
          end else begin
            skid0_q <= skid1_q;
            skid1_q <= fifo_dat_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame FSM with registered result pulses and saturating statistics.
  always_ff @(posedge user_clk or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= StHunt;
      rem_q     <= '0;
      first_q   <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
      drop_cnt  <= '0;
`ifdef AURORA_FRAME_CHK_EN
      chk_q     <= '0;
`endif
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      case (state_q)
        StHunt: begin
          if (head_vld) begin
            if (skid0_q[31:16] == SYNC_WORD) begin
              rem_q   <= skid0_q[15:0];
`ifdef AURORA_FRAME_CHK_EN
              chk_q   <= skid0_q;
`endif
              state_q <= StCheckLen;
            end else begin
              drop_cnt <= sat_inc(drop_cnt);
            end
          end
        end
        StCheckLen: begin
          if (32'(rem_q) > MAX_LEN) begin
            frame_err <= 1'b1;
            err_cnt   <= sat_inc(err_cnt);
            state_q   <= StHunt;
          end else if (rem_q == 16'd0) begin
            state_q <= StTrailer;
          end else begin
            first_q <= 1'b1;
            state_q <= StPayload;
          end
        end
        StPayload: begin
          if (hs) begin
`ifdef AURORA_FRAME_CHK_EN
            chk_q   <= chk_q ^ skid0_q;
`endif
            first_q <= 1'b0;
            rem_q   <= rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              state_q <= StTrailer;
            end
          end
        end
        StTrailer: begin
          if (head_vld) begin
`ifdef AURORA_FRAME_CHK_EN
            if (skid0_q == chk_q) begin
              frame_ok  <= 1'b1;
              frame_cnt <= sat_inc(frame_cnt);
            end else begin
              frame_err <= 1'b1;
              err_cnt   <= sat_inc(err_cnt);
            end
`else
            frame_ok  <= 1'b1;
            frame_cnt <= sat_inc(frame_cnt);
`endif
            state_q <= StHunt;
          end
        end
        default: state_q <= StHunt;
      endcase
    end
  end

endmodule

// File: tb/tb_aurora_rx_frame_parser.sv
// tb_aurora_rx_frame_parser: randomized and directed stimulus for aurora_rx_frame_parser,
// checked against a word-list reference parser. Counters use a narrow width so that
// saturation is reached within the run.

module tb_aurora_rx_frame_parser;

  localparam logic [15:0] Sync   = 16'hA5C3;
  localparam int unsigned MaxLen = 1024;
  localparam int unsigned CntW   = 4;
  localparam int          CntMax = (1 << CntW) - 1;
`ifdef AURORA_FRAME_CHK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic        sof;
    logic        eof;
  } pay_t;

  logic            user_clk = 1'b0;
  logic            rst_in;
  logic [31:0]     fifo_dat_i;
  logic            fifo_empty_i;
  logic            fifo_rd_o;
  logic            frame_ok;
  logic            frame_err;
  logic [CntW-1:0] frame_cnt;
  logic [CntW-1:0] err_cnt;
  logic [CntW-1:0] drop_cnt;

  aurora_rx_frame_parser_if out_if ();

  aurora_rx_frame_parser #(
    .SYNC_WORD (Sync),
    .MAX_LEN   (MaxLen),
    .CNT_W     (CntW)
  ) dut (
    .user_clk     (user_clk),
    .rst_in       (rst_in),
    .fifo_dat_i   (fifo_dat_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rd_o    (fifo_rd_o),
    .out_if       (out_if),
    .frame_ok     (frame_ok),
    .frame_err    (frame_err),
    .frame_cnt    (frame_cnt),
    .err_cnt      (err_cnt),
    .drop_cnt     (drop_cnt)
  );

  always #5 user_clk = ~user_clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] stim_q[$];
  pay_t        exp_pay[$];
  bit          exp_res[$];
  int          m_ok, m_err, m_drop;

  int          cyc = 0;
  int          hs_cnt = 0;
  int          first_rd_cyc, first_valid_cyc;
  int          hs_cyc[$];
  logic        rd_seen, stall_prev, prev_sof, prev_eof;
  logic [31:0] prev_data;
  logic [CntW-1:0] prev_drop;
  int          ready_mode, gap_mode, pat_idx;
  logic [3:0]  ready_pat;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] sat(input int v);
    return (v > CntMax) ? 32'(CntMax) : 32'(v);
  endfunction

  // Append one frame (header, payload, trailer) to the staging list.
  task automatic add_frame(input int len, input bit bad_trl, input bit seq);
    logic [31:0] h, x, p;
    h = {Sync, 16'(len)};
    x = h;
    stim_q.push_back(h);
    for (int k = 0; k < len; k++) begin
      p = seq ? 32'(k + 1) : $urandom;
      stim_q.push_back(p);
      x = x ^ p;
    end
    stim_q.push_back(bad_trl ? (x ^ 32'h1) : x);
  endtask

  // Reference parser: walks the staged word list and queues expected results.
  task automatic launch();
    int i, n, len;
    logic [31:0] w, x, p, t;
    i = 0;
    n = stim_q.size();
    while (i < n) begin
      w = stim_q[i];
      i++;
      if (w[31:16] != Sync) begin
        m_drop++;
      end else begin
        len = int'(w[15:0]);
        if (len > int'(MaxLen)) begin
          exp_res.push_back(1'b0);
          m_err++;
        end else if (i + len < n) begin
          x = w;
          for (int k = 0; k < len; k++) begin
            p = stim_q[i + k];
            x = x ^ p;
            exp_pay.push_back('{d: p, sof: (k == 0), eof: (k == len - 1)});
          end
          i = i + len;
          t = stim_q[i];
          i++;
          if (!ChkEn || t == x) begin
            exp_res.push_back(1'b1);
            m_ok++;
          end else begin
            exp_res.push_back(1'b0);
            m_err++;
          end
        end else begin
          i = n;
        end
      end
    end
    foreach (stim_q[j]) fifo_q.push_back(stim_q[j]);
    stim_q.delete();
    fifo_empty_i = (fifo_q.size() == 0);
  endtask

  // Observe outputs mid-cycle.
  task automatic monitor();
    pay_t e;
    bit   r;
    if (stall_prev) begin
      check_val("hold_valid", 32'(out_if.out_valid), 32'd1);
      check_val("hold_data", out_if.out_data, prev_data);
      check_val("hold_sof", 32'(out_if.out_sof), 32'(prev_sof));
      check_val("hold_eof", 32'(out_if.out_eof), 32'(prev_eof));
    end
    if (fifo_empty_i) check_val("rd_when_empty", 32'(fifo_rd_o), 32'd0);
    if (out_if.out_valid && out_if.out_ready) begin
      hs_cnt++;
      hs_cyc.push_back(cyc);
      if (exp_pay.size() == 0) begin
        check_val("extra_word", out_if.out_data, 32'hFFFF_FFFF ^ out_if.out_data);
      end else begin
        e = exp_pay.pop_front();
        check_val("data", out_if.out_data, e.d);
        check_val("sof", 32'(out_if.out_sof), 32'(e.sof));
        check_val("eof", 32'(out_if.out_eof), 32'(e.eof));
      end
    end
    if (frame_ok || frame_err) begin
      check_val("ok_err_excl", 32'(frame_ok & frame_err), 32'd0);
      check_val("drop_vs_pulse", 32'(drop_cnt), 32'(prev_drop));
      if (exp_res.size() == 0) begin
        check_val("extra_pulse", 32'(exp_res.size()), 32'd1);
      end else begin
        r = exp_res.pop_front();
        check_val("frame_ok", 32'(frame_ok), 32'(r));
      end
    end
    if (first_rd_cyc < 0 && fifo_rd_o) first_rd_cyc = cyc;
    if (first_valid_cyc < 0 && out_if.out_valid) first_valid_cyc = cyc;
    stall_prev = out_if.out_valid & ~out_if.out_ready;
    prev_data  = out_if.out_data;
    prev_sof   = out_if.out_sof;
    prev_eof   = out_if.out_eof;
    prev_drop  = drop_cnt;
  endtask

  // One clock: check at negedge, then model the standard-mode FIFO and drive inputs.
  task automatic tick();
    bit gap;
    @(negedge user_clk);
    cyc++;
    monitor();
    rd_seen = fifo_rd_o;
    @(posedge user_clk);
    #1;
    if (rd_seen) fifo_dat_i = (fifo_q.size() != 0) ? fifo_q.pop_front() : 32'hDEAD_BEEF;
    case (ready_mode)
      0: out_if.out_ready = 1'b1;
      1: begin
        out_if.out_ready = ready_pat[pat_idx % 4];
        pat_idx++;
      end
      default: out_if.out_ready = ($urandom_range(0, 3) != 0);
    endcase
    gap = (gap_mode != 0) && ($urandom_range(0, 3) == 0);
    fifo_empty_i = gap || (fifo_q.size() == 0);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || exp_pay.size() != 0 || exp_res.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check_val("pending_words", 32'(exp_pay.size()), 32'd0);
    check_val("pending_results", 32'(exp_res.size()), 32'd0);
    repeat (10) tick();
    check_val("frame_cnt", 32'(frame_cnt), sat(m_ok));
    check_val("err_cnt", 32'(err_cnt), sat(m_err));
    check_val("drop_cnt", 32'(drop_cnt), sat(m_drop));
  endtask

  task automatic apply_reset();
    rst_in = 1'b1;
    #1;
    check_val("rst_valid", 32'(out_if.out_valid), 32'd0);
    check_val("rst_data", out_if.out_data, 32'd0);
    check_val("rst_sof_eof", 32'({out_if.out_sof, out_if.out_eof}), 32'd0);
    check_val("rst_rd", 32'(fifo_rd_o), 32'd0);
    check_val("rst_pulses", 32'({frame_ok, frame_err}), 32'd0);
    check_val("rst_cnts", 32'({frame_cnt, err_cnt, drop_cnt}), 32'd0);
    fifo_q.delete();
    exp_pay.delete();
    exp_res.delete();
    m_ok = 0;
    m_err = 0;
    m_drop = 0;
    rd_seen = 1'b0;
    stall_prev = 1'b0;
    prev_drop = '0;
    fifo_empty_i = 1'b1;
    fifo_dat_i = '0;
    repeat (2) @(posedge user_clk);
    #1;
    rst_in = 1'b0;
  endtask

  initial begin
    int h0, n, len;
    logic [31:0] g;
    rst_in = 1'b0;
    fifo_empty_i = 1'b1;
    fifo_dat_i = '0;
    out_if.out_ready = 1'b1;
    ready_mode = 0;
    gap_mode = 0;
    pat_idx = 0;
    ready_pat = 4'b1001;
    first_rd_cyc = -1;
    first_valid_cyc = -1;
    #2;

    // Basic frame at full rate: latency and back-to-back payload.
    apply_reset();
    first_rd_cyc = -1;
    first_valid_cyc = -1;
    hs_cyc.delete();
    add_frame(3, 1'b0, 1'b1);
    launch();
    drain(200);
    check_val("latency", 32'(first_valid_cyc - first_rd_cyc), 32'd4);
    if (hs_cyc.size() >= 3) begin
      check_val("thru_1_2", 32'(hs_cyc[1] - hs_cyc[0]), 32'd1);
      check_val("thru_2_3", 32'(hs_cyc[2] - hs_cyc[1]), 32'd1);
    end

    // Corrupted trailer.
    apply_reset();
    add_frame(3, 1'b1, 1'b1);
    launch();
    drain(200);

    // Hunting garbage, then an empty frame.
    apply_reset();
    stim_q.push_back(32'h1234_0000);
    stim_q.push_back(32'h0000_0000);
    add_frame(0, 1'b0, 1'b0);
    launch();
    drain(200);

    // Illegal length, then a short frame and a maximum-length frame.
    apply_reset();
    stim_q.push_back({Sync, 16'h0401});
    add_frame(2, 1'b0, 1'b0);
    add_frame(int'(MaxLen), 1'b0, 1'b0);
    launch();
    drain(3000);

    // Back-pressure pattern with FIFO gaps.
    apply_reset();
    ready_mode = 1;
    gap_mode = 1;
    pat_idx = 0;
    add_frame(8, 1'b0, 1'b0);
    launch();
    drain(500);

    // Reset while payload word 2 of a 4-word frame is presented.
    ready_mode = 0;
    gap_mode = 0;
    apply_reset();
    add_frame(4, 1'b0, 1'b0);
    launch();
    h0 = hs_cnt;
    n = 0;
    while (hs_cnt < h0 + 1 && n < 200) begin
      tick();
      n++;
    end
    check_val("mid_word1_seen", 32'(hs_cnt - h0), 32'd1);
    check_val("mid_word2_valid", 32'(out_if.out_valid), 32'd1);
    apply_reset();
    add_frame(2, 1'b0, 1'b0);
    launch();
    drain(500);

    // Random mix: garbage, illegal lengths, bad trailers, random stalls and gaps.
    apply_reset();
    ready_mode = 2;
    gap_mode = 1;
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        g = $urandom;
        if (g[31:16] == Sync) g[31] = ~g[31];
        stim_q.push_back(g);
      end
      if ($urandom_range(0, 9) == 0) begin
        len = int'(MaxLen) + 1 + int'($urandom_range(0, 1000));
        stim_q.push_back({Sync, 16'(len)});
      end else begin
        add_frame(int'($urandom_range(0, 12)), ($urandom_range(0, 9) < 3), 1'b0);
      end
    end
    launch();
    drain(20000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
